alu_operand_fetch: RTL and testbench
====================================

Name: alu_operand_fetch

Overview:
- Upstream feeder for the 16-bit datapath ALU.
- Accepts one operand-fetch command and reads Rn, then Rm, over the single synchronous read port of the 8x16 register file.
- Applies the 1-bit shifter to the Rm value, or substitutes a 16-bit immediate for B.
- Presents val_A / val_B to the ALU stage under a valid/ready handshake, and holds them stable until consumed.

Parameters:
- DATA_W, 16, operand width; equals the ALU operand width.
- RADDR_W, 3, register-file address width (8 registers).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- rn  input  RADDR_W  A-operand register index.
- rm  input  RADDR_W  B-operand register index.
- shift  input  2  B shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (MSB copied).
- bsel_imm  input  1  1: B = imm, unshifted; Rm is not read.
- asel_zero  input  1  1: A = 0; Rn is not read.
- imm  input  DATA_W  immediate for B.
- rf_raddr  output  RADDR_W  register-file read address.
- rf_rdata  input  DATA_W  register-file read data; valid the cycle after rf_raddr is presented.
- val_A  output  DATA_W  A operand to the ALU.
- val_B  output  DATA_W  B operand to the ALU.
- op_valid  output  1  operands valid.
- op_ready  input  1  ALU/result stage accepts the operands.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; val_A, val_B, rf_raddr all 0; op_valid 0; busy 0.
- Reset mid-operation aborts the command; no operands are emitted afterwards.
- Command capture:
  - In IDLE with start=1, the clock edge registers rn, rm, shift, bsel_imm, asel_zero and imm.
  - These inputs are ignored at all other times.
  - start while busy is dropped, not queued.
- States: IDLE, FETCH_A, CAP_A, FETCH_B, CAP_B, OUT.
- IDLE:
  - rf_raddr = 0.
  - On start, next state:
    - asel_zero=0 -> FETCH_A;
    - asel_zero=1, bsel_imm=0 -> FETCH_B;
    - both=1 -> OUT, loading val_A=0 and val_B=imm on the same edge.
- FETCH_A: rf_raddr = rn_q; -> CAP_A.
- CAP_A:
  - val_A <= rf_rdata.
  - If bsel_imm: val_B <= imm_q, -> OUT.
  - Else: rf_raddr = rm_q (read overlapped), -> CAP_B.
- FETCH_B: rf_raddr = rm_q; val_A <= 0; -> CAP_B.
- CAP_B: val_B <= shift(rf_rdata, shift_q); -> OUT.
- OUT:
  - op_valid=1; val_A/val_B held stable.
  - On op_valid & op_ready, -> IDLE.
  - op_valid deasserts the following cycle; no back-to-back command is accepted in the handshake cycle.
- Latency, start edge to first op_valid cycle:
  - 4 cycles for a full two-register read;
  - 3 cycles when exactly one of asel_zero / bsel_imm is set;
  - 1 cycle when both are set.
- Shifter:
  - LSL1: {x[DATA_W-2:0],0}.
  - LSR1: {0,x[DATA_W-1:1]}.
  - ASR1: {x[DATA_W-1],x[DATA_W-1:1]}.
  - Never applied to imm.
- rn == rm is legal; the register is read twice, with no special case.
- op_ready may be high before op_valid; this has no effect outside OUT.
- busy is purely state-decoded, with no combinational path from start.
- Outputs retain their last values in IDLE; only op_valid qualifies them.

Test Plan:
- Reset mid-flight: assert reset_n=0 during CAP_A -> op_valid=0, val_A=val_B=0, rf_raddr=0 immediately; after release, state IDLE and busy=0.
- Full read: R2=0x1234, R5=0x8001, rn=2, rm=5, shift=11, op_ready=1 -> rf_raddr sequence 2 then 5; op_valid exactly 4 cycles after start for one cycle; val_A=0x1234, val_B=0xC000.
- Immediate B: rn=3 (R3=0x00FF), bsel_imm=1, imm=0x0F0F, shift=01 -> op_valid at 3 cycles; val_A=0x00FF, val_B=0x0F0F (shift ignored); rm never driven on rf_raddr.
- Zero A plus LSR1: asel_zero=1, rm=7 (R7=0xFFFF), shift=10 -> op_valid at 3 cycles; val_A=0, val_B=0x7FFF; rn never driven on rf_raddr.
- Both bypass plus backpressure: asel_zero=1, bsel_imm=1, imm=0xABCD, op_ready=0 for 5 cycles -> op_valid at 1 cycle, held with val_A=0, val_B=0xABCD stable for 5 cycles; drops the cycle after op_ready=1.
- Busy start: second start with rn=1 while in CAP_B -> ignored; operands match the first command; busy low only after the OUT handshake.

Source files
------------

// File: rtl/alu_operand_fetch_if.sv
// Operand-fetch command, register-file read port and ALU operand handshake.
// The slave modport is the fetch unit; the master modport is its environment.
interface alu_operand_fetch_if #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
);
    logic               start;
    logic [RADDR_W-1:0] rn;
    logic [RADDR_W-1:0] rm;
    logic [1:0]         shift;
    logic               bsel_imm;
    logic               asel_zero;
    logic [DATA_W-1:0]  imm;
    logic [RADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0]  rf_rdata;
    logic [DATA_W-1:0]  val_A;
    logic [DATA_W-1:0]  val_B;
    logic               op_valid;
    logic               op_ready;
    logic               busy;

    modport slave (
        input  start, rn, rm, shift, bsel_imm, asel_zero, imm, rf_rdata, op_ready,
        output rf_raddr, val_A, val_B, op_valid, busy
    );

    modport master (
        output start, rn, rm, shift, bsel_imm, asel_zero, imm, rf_rdata, op_ready,
        input  rf_raddr, val_A, val_B, op_valid, busy
    );
endinterface

// File: rtl/alu_operand_fetch.sv
// Fetches Rn/Rm over one sync register-file read port, shifts B or substitutes imm.
// Latency start->op_valid: 4 cycles (two reads), 3 (one read), 1 (no reads).
// Operands held stable under op_valid until op_ready; start while busy is dropped.
module alu_operand_fetch #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_operand_fetch_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        CAP_A   = 3'd2,
        FETCH_B = 3'd3,
        CAP_B   = 3'd4,
        OUT     = 3'd5
    } state_t;

    typedef struct packed {
        logic [RADDR_W-1:0] rn;
        logic [RADDR_W-1:0] rm;
        logic [1:0]         shift;
        logic               bsel_imm;
        logic [DATA_W-1:0]  imm;
    } cmd_t;

    state_t             state_q, state_nxt;
    cmd_t               cmd_q;
    logic               cmd_cap;
    logic [DATA_W-1:0]  val_a_q, val_b_q;
    logic               a_ld, b_ld;
    logic [DATA_W-1:0]  a_nxt, b_nxt;
    logic [RADDR_W-1:0] raddr;

    function automatic logic [DATA_W-1:0] shift1(input logic [DATA_W-1:0] x,
                                                 input logic [1:0]        s);
        logic [DATA_W-1:0] r;
        case (s)
            2'b01:   r = {x[DATA_W-2:0], 1'b0};
            2'b10:   r = {1'b0, x[DATA_W-1:1]};
            2'b11:   r = {x[DATA_W-1], x[DATA_W-1:1]};
            default: r = x;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            val_a_q <= '0;
            val_b_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (cmd_cap) begin
                cmd_q.rn       <= bus.rn;
                cmd_q.rm       <= bus.rm;
                cmd_q.shift    <= bus.shift;
                cmd_q.bsel_imm <= bus.bsel_imm;
                cmd_q.imm      <= bus.imm;
            end
            if (a_ld) val_a_q <= a_nxt;
            if (b_ld) val_b_q <= b_nxt;
        end
    end

    // Read data arrives one cycle after the address, so each CAP state
    // consumes the address presented in the state before it.
    always_comb begin
        state_nxt = state_q;
        cmd_cap   = 1'b0;
        raddr     = '0;
        a_ld      = 1'b0;
        a_nxt     = '0;
        b_ld      = 1'b0;
        b_nxt     = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cmd_cap = 1'b1;
                    if (!bus.asel_zero) begin
                        state_nxt = FETCH_A;
                    end else if (!bus.bsel_imm) begin
                        state_nxt = FETCH_B;
                    end else begin
                        state_nxt = OUT;
                        a_ld      = 1'b1;
                        b_ld      = 1'b1;
                        b_nxt     = bus.imm;
                    end
                end
            end
            FETCH_A: begin
                raddr     = cmd_q.rn;
                state_nxt = CAP_A;
            end
            CAP_A: begin
                a_ld  = 1'b1;
                a_nxt = bus.rf_rdata;
                if (cmd_q.bsel_imm) begin
                    b_ld      = 1'b1;
                    b_nxt     = cmd_q.imm;
                    state_nxt = OUT;
                end else begin
                    raddr     = cmd_q.rm;
                    state_nxt = CAP_B;
                end
            end
            FETCH_B: begin
                raddr     = cmd_q.rm;
                a_ld      = 1'b1;
                state_nxt = CAP_B;
            end
            CAP_B: begin
                b_ld      = 1'b1;
                b_nxt     = shift1(bus.rf_rdata, cmd_q.shift);
                state_nxt = OUT;
            end
            OUT: begin
                if (bus.op_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rf_raddr = raddr;
    assign bus.val_A    = val_a_q;
    assign bus.val_B    = val_b_q;
    assign bus.op_valid = (state_q == OUT);
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed table plus randomized commands against a register-file/operand model.
module tb_alu_operand_fetch;

    logic clk;
    logic reset_n;
    logic [15:0] rf [8];
    int n_checks = 0;
    int n_fail   = 0;

    alu_operand_fetch_if #(.DATA_W(16), .RADDR_W(3)) bus();

    alu_operand_fetch #(.DATA_W(16), .RADDR_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read register file.
    always @(posedge clk) bus.rf_rdata <= rf[bus.rf_raddr];

    typedef struct {
        logic        asel;
        logic        bsel;
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [1:0]  sh;
        logic [15:0] imm;
        int          hold;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] shift_ref(input logic [15:0] x, input logic [1:0] s);
        logic [31:0] w;
        w = 32'(x);
        case (s)
            2'd1:    return 16'((w * 2) % 65536);
            2'd2:    return 16'(w / 2);
            2'd3:    return 16'((w / 2) + (w & 32'h8000));
            default: return x;
        endcase
    endfunction

    function automatic int lat_ref(input logic asel, input logic bsel);
        if (asel && bsel) return 1;
        if (asel || bsel) return 3;
        return 4;
    endfunction

    task automatic noise();
        bus.start     = 1'($urandom);
        bus.rn        = 3'($urandom);
        bus.rm        = 3'($urandom);
        bus.shift     = 2'($urandom);
        bus.bsel_imm  = 1'($urandom);
        bus.asel_zero = 1'($urandom);
        bus.imm       = 16'($urandom);
    endtask

    task automatic run_cmd(input logic asel, input logic bsel, input logic [2:0] rn,
                           input logic [2:0] rm, input logic [1:0] sh, input logic [15:0] imm,
                           input int hold, input logic [15:0] exp_a, input logic [15:0] exp_b,
                           input int exp_lat);
        int lat;
        int hold_eff;
        int hits;
        logic [2:0] reads[$];
        logic [2:0] addr_log[$];
        if (!asel) reads.push_back(rn);
        if (!bsel) reads.push_back(rm);
        @(negedge clk);
        bus.start = 1'b1; bus.rn = rn; bus.rm = rm; bus.shift = sh;
        bus.asel_zero = asel; bus.bsel_imm = bsel; bus.imm = imm;
        bus.op_ready = (hold == 0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            noise();
            if (bus.op_valid) begin
                lat = k;
                break;
            end
            addr_log.push_back(bus.rf_raddr);
        end
        if (lat == 0) begin
            chk("op_valid timeout", 32'd0, 32'd1);
            bus.start = 1'b0;
            return;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("val_A", 32'(bus.val_A), 32'(exp_a));
        chk("val_B", 32'(bus.val_B), 32'(exp_b));
        for (int i = 0; i < reads.size(); i++) begin
            if (i < addr_log.size()) chk("rf_raddr order", 32'(addr_log[i]), 32'(reads[i]));
            else chk("rf_raddr missing", 32'd0, 32'd1);
        end
        hits = 0;
        if (asel && !bsel && rn != rm && rn != 3'd0) begin
            foreach (addr_log[i]) if (addr_log[i] == rn) hits++;
            chk("rn not read", 32'(hits), 32'd0);
        end
        if (bsel && !asel && rm != rn && rm != 3'd0) begin
            foreach (addr_log[i]) if (addr_log[i] == rm) hits++;
            chk("rm not read", 32'(hits), 32'd0);
        end
        hold_eff = (hold < 1) ? 1 : hold;
        for (int i = 1; i < hold_eff; i++) begin
            @(negedge clk);
            noise();
            chk("held op_valid", 32'(bus.op_valid), 32'd1);
            chk("held val_A", 32'(bus.val_A), 32'(exp_a));
            chk("held val_B", 32'(bus.val_B), 32'(exp_b));
        end
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("op_valid drop", 32'(bus.op_valid), 32'd0);
        chk("busy after handshake", 32'(bus.busy), 32'd0);
        chk("val_A retained", 32'(bus.val_A), 32'(exp_a));
        chk("val_B retained", 32'(bus.val_B), 32'(exp_b));
        bus.op_ready = 1'b0;
    endtask

    initial begin
        logic        asel, bsel;
        logic [2:0]  rn, rm;
        logic [1:0]  sh;
        logic [15:0] imm, ea, eb;
        int          seen;

        rf[0] = 16'h5A5A; rf[1] = 16'h1111; rf[2] = 16'h1234; rf[3] = 16'h00FF;
        rf[4] = 16'h4321; rf[5] = 16'h8001; rf[6] = 16'h0F00; rf[7] = 16'hFFFF;

        //          asel  bsel  rn    rm    sh     imm       hold  A         B         lat
        vecs[0] = '{1'b0, 1'b0, 3'd2, 3'd5, 2'b11, 16'h0000, 0, 16'h1234, 16'hC000, 4};
        vecs[1] = '{1'b0, 1'b1, 3'd3, 3'd6, 2'b01, 16'h0F0F, 0, 16'h00FF, 16'h0F0F, 3};
        vecs[2] = '{1'b1, 1'b0, 3'd4, 3'd7, 2'b10, 16'h0000, 0, 16'h0000, 16'h7FFF, 3};
        vecs[3] = '{1'b1, 1'b1, 3'd2, 3'd5, 2'b11, 16'hABCD, 5, 16'h0000, 16'hABCD, 1};
        vecs[4] = '{1'b0, 1'b0, 3'd5, 3'd5, 2'b01, 16'h0000, 0, 16'h8001, 16'h0002, 4};
        vecs[5] = '{1'b0, 1'b0, 3'd7, 3'd2, 2'b00, 16'h0000, 2, 16'hFFFF, 16'h1234, 4};
        vecs[6] = '{1'b0, 1'b0, 3'd0, 3'd5, 2'b10, 16'h0000, 0, 16'h5A5A, 16'h4000, 4};
        vecs[7] = '{1'b1, 1'b0, 3'd1, 3'd7, 2'b11, 16'h0000, 1, 16'h0000, 16'hFFFF, 3};

        reset_n = 1'b0;
        bus.start = 1'b0; bus.rn = '0; bus.rm = '0; bus.shift = '0;
        bus.bsel_imm = 1'b0; bus.asel_zero = 1'b0; bus.imm = '0; bus.op_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset op_valid", 32'(bus.op_valid), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset val_A", 32'(bus.val_A), 32'd0);
        chk("reset val_B", 32'(bus.val_B), 32'd0);
        chk("reset rf_raddr", 32'(bus.rf_raddr), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_cmd(vecs[i].asel, vecs[i].bsel, vecs[i].rn, vecs[i].rm, vecs[i].sh,
                    vecs[i].imm, vecs[i].hold, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_lat);

        // Start during CAP_B is dropped; the first command completes untouched.
        @(negedge clk);
        bus.start = 1'b1; bus.rn = 3'd2; bus.rm = 3'd5; bus.shift = 2'b00;
        bus.asel_zero = 1'b0; bus.bsel_imm = 1'b0; bus.op_ready = 1'b0;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.rn = 3'd1; bus.asel_zero = 1'b1; bus.bsel_imm = 1'b1; bus.imm = 16'hDEAD;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy-start op_valid", 32'(bus.op_valid), 32'd1);
        chk("busy-start val_A", 32'(bus.val_A), 32'h1234);
        chk("busy-start val_B", 32'(bus.val_B), 32'h8001);
        chk("busy-start busy in OUT", 32'(bus.busy), 32'd1);
        bus.op_ready = 1'b1;
        @(negedge clk);
        chk("busy-start busy released", 32'(bus.busy), 32'd0);
        chk("busy-start op_valid drop", 32'(bus.op_valid), 32'd0);
        bus.op_ready = 1'b0;

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) rf[3'($urandom)] = 16'($urandom);
            asel = 1'($urandom); bsel = 1'($urandom);
            rn = 3'($urandom); rm = 3'($urandom); sh = 2'($urandom); imm = 16'($urandom);
            ea = asel ? 16'h0000 : rf[rn];
            eb = bsel ? imm : shift_ref(rf[rm], sh);
            run_cmd(asel, bsel, rn, rm, sh, imm, $urandom_range(0, 3), ea, eb, lat_ref(asel, bsel));
        end

        // Reset during CAP_A aborts the command.
        @(negedge clk);
        bus.start = 1'b1; bus.rn = 3'd4; bus.rm = 3'd6; bus.shift = 2'b00;
        bus.asel_zero = 1'b0; bus.bsel_imm = 1'b0; bus.op_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset op_valid", 32'(bus.op_valid), 32'd0);
        chk("midreset val_A", 32'(bus.val_A), 32'd0);
        chk("midreset val_B", 32'(bus.val_B), 32'd0);
        chk("midreset rf_raddr", 32'(bus.rf_raddr), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.op_valid) seen++;
        end
        chk("post-reset no operands", 32'(seen), 32'd0);
        chk("post-reset busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
